// File: rtl/sram_obi_ctrl_pkg.sv
// Shared types and helpers for the OBI-to-SRAM controller.
// Holds the controller state encoding, address-split helpers and byte-to-bit mask expansion.
package sram_obi_ctrl_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int BYTE_W = 8;

    // Number of byte-offset bits below the word index.
    function automatic int lsb_of(input int width);
        return $clog2(width / BYTE_W);
    endfunction

    // Number of word-index bits.
    function automatic int aw_of(input int words);
        return $clog2(words);
    endfunction

    // One byte enable becomes eight active-low SRAM bit-write enables.
    function automatic logic [BYTE_W-1:0] be_to_wen(input logic be);
        return {BYTE_W{~be}};
    endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Post-reset clear sequencer: walks word addresses 0..WORDS-1, one per cycle.
// Latency: WORDS cycles from reset release to done; no backpressure, it never stalls.
module sram_init_seq
    import sram_obi_ctrl_pkg::*;
#(
    parameter int WORDS      = 256,
    parameter int INIT_CLEAR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [$clog2(WORDS)-1:0] init_addr,
    output logic                     init_last,
    output logic                     init_done
);

    localparam int AW = aw_of(WORDS);

    logic [AW-1:0] cnt_q;
    logic          done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= (INIT_CLEAR == 0);
        end else if (!done_q) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == AW'(WORDS - 1)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign init_addr = cnt_q;
    assign init_last = !done_q && (cnt_q == AW'(WORDS - 1));
    assign init_done = done_q;

endmodule

// File: rtl/sram_obi_ctrl.sv
// OBI-style single-cycle bus to active-low banked SRAM; optional zero-fill after reset.
// Response one cycle after grant; gnt = req once ready, so no backpressure beyond the clear phase.
module sram_obi_ctrl
    import sram_obi_ctrl_pkg::*;
#(
    parameter int                WORDS      = 256,
    parameter int                WIDTH      = 64,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                INIT_CLEAR = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req,
    output logic                     gnt,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     we,
    input  logic [WIDTH/8-1:0]       be,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic                     err,
    output logic                     init_done,
    output logic                     sram_cen,
    output logic                     sram_gwen,
    output logic [WIDTH-1:0]         sram_wen,
    output logic [$clog2(WORDS)-1:0] sram_addr,
    output logic [WIDTH-1:0]         sram_din,
    input  logic [WIDTH-1:0]         sram_dout
);

    localparam int LSB   = lsb_of(WIDTH);
    localparam int AW    = aw_of(WORDS);
    localparam int BYTES = WIDTH / BYTE_W;

    if (WIDTH % BYTE_W != 0) begin : g_chk_width
        $error("sram_obi_ctrl: WIDTH must be a multiple of 8");
    end
    if (WORDS < 2 || (WORDS & (WORDS - 1)) != 0) begin : g_chk_words
        $error("sram_obi_ctrl: WORDS must be a power of two");
    end
    if (BASE_ADDR[LSB+AW-1:0] != '0) begin : g_chk_base
        $error("sram_obi_ctrl: BASE_ADDR not aligned to the window size");
    end

    state_t            state_q, state_d;
    logic [AW-1:0]     init_addr;
    logic              init_last;
    logic              in_win;
    logic [AW-1:0]     word_idx;
    logic [WIDTH-1:0]  be_mask;
    logic              rvalid_q, err_q, rd_q;
    logic [WIDTH-1:0]  hold_q;
    logic              unused_addr;

    sram_init_seq #(
        .WORDS      (WORDS),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .init_addr (init_addr),
        .init_last (init_last),
        .init_done (init_done)
    );

    // Byte-offset bits take no part in decode.
    assign unused_addr = ^addr;
    assign in_win      = (addr[ADDR_W-1:LSB+AW] == BASE_ADDR[ADDR_W-1:LSB+AW]);
    assign word_idx    = addr[LSB +: AW];

    for (genvar k = 0; k < BYTES; k++) begin : g_mask
        assign be_mask[BYTE_W*k +: BYTE_W] = be_to_wen(be[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (INIT_CLEAR != 0) ? INIT : READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Gated by rst so every combinational output shows its idle value during reset.
    always_comb begin
        state_d   = state_q;
        gnt       = 1'b0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_addr = '0;
        sram_din  = '0;
        if (!rst) begin
            unique case (state_q)
                INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_addr = init_addr;
                    if (init_last) begin
                        state_d = READY;
                    end
                end
                READY: begin
                    gnt = req;
                    if (req && in_win) begin
                        sram_cen  = 1'b0;
                        sram_addr = word_idx;
                        if (we) begin
                            sram_gwen = 1'b0;
                            sram_wen  = be_mask;
                            sram_din  = wdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_q     <= 1'b0;
            hold_q   <= '0;
        end else begin
            rvalid_q <= gnt;
            err_q    <= gnt && !in_win;
            rd_q     <= gnt && in_win && !we;
            if (rvalid_q && rd_q) begin
                hold_q <= sram_dout;
            end
        end
    end

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign rdata  = rd_q ? sram_dout : hold_q;

endmodule

// File: tb/tb_sram_obi_ctrl.sv
// Randomized bench for sram_obi_ctrl against a transaction-level memory model.
module tb_sram_obi_ctrl;

    localparam int          WORDS = 256;
    localparam int          WIDTH = 64;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, gnt, we, rvalid, err, init_done;
    logic [31:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata, rdata;
    logic        sram_cen, sram_gwen;
    logic [63:0] sram_wen, sram_din;
    logic [63:0] sram_dout = '0;
    logic [7:0]  sram_addr;

    always #5 clk = ~clk;

    sram_obi_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .addr      (addr),
        .we        (we),
        .be        (be),
        .wdata     (wdata),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .err       (err),
        .init_done (init_done),
        .sram_cen  (sram_cen),
        .sram_gwen (sram_gwen),
        .sram_wen  (sram_wen),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    // Behavioural SRAM; filled with garbage during reset so the clear is visible.
    logic [63:0] sram [WORDS];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) sram[i] <= {$urandom, $urandom};
        end else if (!sram_cen) begin
            if (!sram_gwen) sram[sram_addr] <= (sram[sram_addr] & sram_wen) | (sram_din & ~sram_wen);
            else            sram_dout <= sram[sram_addr];
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [63:0] ref_mem [WORDS];
    logic [63:0] hold_m = '0;
    logic [63:0] exp_rdata = '0;
    bit          ready_m = 0;
    bit          exp_vld = 0;
    bit          exp_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] byte_mask(input logic [7:0] b);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = b[k] ? 8'hFF : 8'h00;
        return m;
    endfunction

    task automatic check_reset_outputs();
        check("rst_gnt", gnt, 0);
        check("rst_resp", {rvalid, err}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", init_done, 0);
        check("rst_ctrl", {sram_cen, sram_gwen}, 2'b11);
        check("rst_wen", sram_wen, '1);
        check("rst_addr", sram_addr, 0);
        check("rst_din", sram_din, 0);
    endtask

    // Checks n cycles of the clear phase, starting just after reset release.
    task automatic run_init(input int n);
        exp_vld = 0;
        ready_m = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("init_flags", {gnt, rvalid, init_done}, 0);
            check("init_pins", {sram_cen, sram_gwen, sram_addr}, {2'b00, 8'(i)});
            check("init_wen", sram_wen, 0);
            check("init_din", sram_din, 0);
        end
        if (n == WORDS) begin
            ready_m = 1;
            hold_m  = '0;
            for (int i = 0; i < WORDS; i++) ref_mem[i] = '0;
        end
    endtask

    // One bus cycle: check the previous response, apply a request, check grant and SRAM pins.
    task automatic do_cycle(input bit r, input logic [31:0] a, input bit w,
                            input logic [7:0] b, input logic [63:0] d);
        logic [7:0]  idx;
        logic [63:0] m;
        bit          inwin, g;
        @(negedge clk);
        check("init_done", init_done, ready_m);
        if (exp_vld) begin
            check("rvalid", rvalid, 1);
            check("err", err, exp_err);
            check("rdata", rdata, exp_rdata);
        end else begin
            check("rvalid_idle", rvalid, 0);
            check("rdata_hold", rdata, hold_m);
        end
        req = r; addr = a; we = w; be = b; wdata = d;
        #1;
        g     = r && ready_m;
        idx   = a[10:3];
        inwin = (a[31:11] == BASE[31:11]);
        check("gnt", gnt, g);
        if (g && inwin) begin
            check("cen", sram_cen, 0);
            check("saddr", sram_addr, idx);
            exp_err = 0;
            if (w) begin
                m = byte_mask(b);
                check("gwen_wr", sram_gwen, 0);
                check("wen_wr", sram_wen, ~m);
                check("din", sram_din, d);
                ref_mem[idx] = (ref_mem[idx] & ~m) | (d & m);
            end else begin
                check("gwen_rd", sram_gwen, 1);
                check("wen_rd", sram_wen, '1);
                hold_m = ref_mem[idx];
            end
            exp_rdata = hold_m;
        end else if (g) begin
            check("cen_oow", sram_cen, 1);
            exp_err   = 1;
            exp_rdata = hold_m;
        end else begin
            check("idle_ctrl", {sram_cen, sram_gwen}, 2'b11);
            check("idle_wen", sram_wen, '1);
            check("idle_addr", sram_addr, 0);
            check("idle_din", sram_din, 0);
        end
        exp_vld = g;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        rst = 1; req = 1; addr = BASE; we = 0; be = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst = 0;

        // Reset in the middle of the clear, at word 100.
        run_init(100);
        @(posedge clk);
        #1 check("init_w100", sram_addr, 100);
        #2 rst = 1;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 rst = 0;
        run_init(WORDS);

        // req still high: first grant lands on the cycle init_done rises.
        do_cycle(1, BASE + 32'h40, 0, 8'h00, 64'h0);

        do_cycle(1, BASE + 32'h18, 1, 8'h0F, 64'hAAAA_BBBB_CCCC_DDDD);
        do_cycle(1, BASE + 32'h18, 0, 8'h00, 64'h0);
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);
        check("raw_const", rdata, 64'h0000_0000_CCCC_DDDD);

        do_cycle(1, BASE + 32'h08, 1, 8'hFF, 64'h11);
        do_cycle(1, BASE + 32'h10, 1, 8'hFF, 64'h22);
        do_cycle(1, BASE + 32'h18, 1, 8'hFF, 64'h33);
        do_cycle(1, BASE + 32'h08, 0, 8'h00, 64'h0);
        do_cycle(1, BASE + 32'h10, 0, 8'h00, 64'h0);
        do_cycle(1, BASE + 32'h18, 0, 8'h00, 64'h0);
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);
        check("hold_const", rdata, 64'h33);

        do_cycle(1, BASE + 32'h800, 0, 8'h00, 64'h0);
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);
        check("oow_hold_const", rdata, 64'h33);

        do_cycle(1, BASE + 32'h20, 1, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
        do_cycle(1, BASE + 32'h20, 0, 8'h00, 64'h0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 7))
                0:       a = BASE ^ (32'h800 << $urandom_range(0, 20));
                1, 2, 3: a = BASE | (32'($urandom_range(0, 7)) << 3) | 32'($urandom_range(0, 7));
                default: a = BASE | (32'($urandom_range(0, 255)) << 3) | 32'($urandom_range(0, 7));
            endcase
            do_cycle($urandom_range(0, 3) != 0, a, $urandom_range(0, 1) == 1,
                     ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                     {$urandom, $urandom});
        end
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);

        // Reset between a read grant and its response edge drops the response.
        do_cycle(1, BASE + 32'h18, 0, 8'h00, 64'h0);
        #2 rst = 1;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 check("rst_pending_rvalid", rvalid, 0);
        check("rst_pending_rdata", rdata, 0);
        @(posedge clk);
        #1 rst = 0;
        run_init(WORDS);
        do_cycle(1, BASE + 32'h18, 0, 8'h00, 64'h0);
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);
        do_cycle(0, 32'h0, 0, 8'h00, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
